// File: rtl/cpu_pkg.sv
// Shared CPU-side types for the instruction-memory boot loader.
// Contents: loader FSM state encoding and the canonical NOP instruction word.
// No ports; imported by imem_loader and its sub-modules.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } loader_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words (lane 0 = first byte).
// Ports: Clk/Rst_n; clear_i restarts the lane counter; accept_i strobes byte_i in;
//        word_o is the assembled register; word_valid_o flags the accept that fills lane 3.
module byte_packer (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [31:0] data_q, data_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  always_comb begin
    data_d     = data_q;
    byte_cnt_d = byte_cnt_q;
    if (clear_i) begin
      byte_cnt_d = 2'd0;
    end else if (accept_i) begin
      case (byte_cnt_q)
        2'd0:    data_d[7:0]   = byte_i;
        2'd1:    data_d[15:8]  = byte_i;
        2'd2:    data_d[23:16] = byte_i;
        default: data_d[31:24] = byte_i;
      endcase
      // Two-bit counter wraps naturally back to lane 0 for the next word.
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q     <= 32'd0;
      byte_cnt_q <= 2'd0;
    end else begin
      data_q     <= data_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign word_o       = data_q;
  assign word_valid_o = accept_i && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader / port arbiter: packs a byte stream into words written at word addresses 0..Len-1,
// stalling the CPU meanwhile; when idle, forwards PC to the shared memory address port.
// Ports: Start/Len request; Rx_* byte stream; PC in; Mem_* memory port; Cpu_Stall/Busy/Done/Err status.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int LEN_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [LEN_W-1:0] Len,
  input  logic [7:0]       Rx_Data,
  input  logic             Rx_Valid,
  output logic             Rx_Ready,
  input  logic [31:0]      PC,
  output logic [31:0]      Mem_Addr,
  output logic [31:0]      Mem_Data,
  output logic             Mem_WE,
  output logic             Cpu_Stall,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int          IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;

  logic        len_ok;
  logic        accept;
  logic        clear;
  logic        word_valid;
  logic        last_word;
  logic [31:0] word;

  assign len_ok    = (Len != '0) && (32'(Len) <= DEPTH_U);
  assign accept    = Rx_Valid && Rx_Ready;
  assign clear     = (state_q == IDLE) && Start && len_ok;
  // len_q >= 1 whenever we are past IDLE, so the subtraction never underflows here.
  assign last_word = (32'(word_idx_q) == (32'(len_q) - 32'd1));

  byte_packer u_packer (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .clear_i      (clear),
    .accept_i     (accept),
    .byte_i       (Rx_Data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if (len_ok) begin
            len_d      = Len;
            word_idx_d = '0;
            state_d    = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
        if (last_word) begin
          state_d = FIN;
        end else begin
          word_idx_d = word_idx_q + IDX_W'(1);
          state_d    = RECV;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  assign Rx_Ready  = (state_q == RECV);
  assign Mem_WE    = (state_q == WRITE);
  assign Busy      = (state_q != IDLE);
  assign Cpu_Stall = Busy;
  assign Done      = (state_q == FIN);
  assign Err       = err_q;
  assign Mem_Data  = word;
  // The CPU owns the address port only while idle; this path is combinational from PC.
  assign Mem_Addr  = (state_q == IDLE) ? PC
                                       : {{(30-IDX_W){1'b0}}, word_idx_q, 2'b00};

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import cpu_pkg::*;

  localparam int MEM_DEPTH = 256;
  localparam int LEN_W     = 16;

  logic             Clk      = 1'b0;
  logic             Rst_n    = 1'b0;
  logic             Start    = 1'b0;
  logic [LEN_W-1:0] Len      = '0;
  logic [7:0]       Rx_Data  = '0;
  logic             Rx_Valid = 1'b0;
  logic [31:0]      PC       = '0;
  logic             Rx_Ready;
  logic [31:0]      Mem_Addr;
  logic [31:0]      Mem_Data;
  logic             Mem_WE;
  logic             Cpu_Stall;
  logic             Busy;
  logic             Done;
  logic             Err;

  imem_loader #(.MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Len       (Len),
    .Rx_Data   (Rx_Data),
    .Rx_Valid  (Rx_Valid),
    .Rx_Ready  (Rx_Ready),
    .PC        (PC),
    .Mem_Addr  (Mem_Addr),
    .Mem_Data  (Mem_Data),
    .Mem_WE    (Mem_WE),
    .Cpu_Stall (Cpu_Stall),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Cycle counter and negedge observer of the memory port and status pulses.
  int          cyc = 0;
  logic [63:0] we_q[$];
  int          last_we_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  int          bad_rdy = 0, busy_hi = 0, busy_rise_cyc = 0, stall_fall_cyc = 0;
  logic        busy_prev = 1'b0, stall_prev = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Mem_WE) begin
      we_q.push_back({Mem_Addr, Mem_Data});
      last_we_cyc = cyc;
    end
    if (Done) begin done_cnt++; done_cyc = cyc; end
    if (Err) begin err_cnt++; err_cyc = cyc; end
    if (Rx_Ready && Mem_WE) bad_rdy++;
    if (Busy) busy_hi++;
    if (Busy && !busy_prev) busy_rise_cyc = cyc;
    if (!Cpu_Stall && stall_prev) stall_fall_cyc = cyc;
    busy_prev  = Busy;
    stall_prev = Cpu_Stall;
  end

  // Reference model: the load image as words, and the byte stream it implies.
  logic [31:0] words[$];
  logic [7:0]  rx_bytes[$];
  int          start_cyc = 0, done_before = 0, err_before = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic make_bytes();
    rx_bytes.delete();
    foreach (words[i]) begin
      logic [31:0] w;
      w = words[i];
      for (int b = 0; b < 4; b++) rx_bytes.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic gen(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
    make_bytes();
  endtask

  // Issue Start with Len=n and stream nfeed bytes; optionally re-pulse Start mid-load.
  task automatic feed(input int n, input int mode, input int nfeed, input bit poke_start);
    int idx;
    int k;
    int budget;
    idx = 0;
    k = 0;
    budget = 40 * n + 40;
    we_q.delete();
    done_before = done_cnt;
    err_before  = err_cnt;
    @(posedge Clk); #1;
    Start = 1'b1;
    Len   = LEN_W'(n);
    while (idx < nfeed && k < budget) begin
      if (poke_start && k == 7) begin Start = 1'b1; Len = LEN_W'(1); end
      Rx_Valid = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 1) : 1'($urandom_range(0, 1));
      Rx_Data  = rx_bytes[idx];
      PC       = $urandom;
      @(negedge Clk);
      if (k == 0) start_cyc = cyc;
      if (Rx_Valid && Rx_Ready) idx++;
      @(posedge Clk); #1;
      Start = 1'b0;
      k++;
    end
    Rx_Valid = 1'b0;
    check("feed_bytes_accepted", idx, nfeed);
  endtask

  task automatic finish_load(input int n, input int mode);
    for (int i = 0; i < 20 && done_cnt == done_before; i++) begin
      @(posedge Clk); #1;
    end
    check("done_pulses", done_cnt - done_before, 1);
    check("we_count", we_q.size(), n);
    for (int i = 0; i < n && i < we_q.size(); i++) begin
      check("we_addr", we_q[i][63:32], 32'(4 * i));
      check("we_data", we_q[i][31:0], words[i]);
    end
    check("done_after_last_we", done_cyc, last_we_cyc + 1);
    check("busy_rise", busy_rise_cyc, start_cyc + 1);
    if (mode == 0) check("load_cycles", done_cyc - start_cyc, 5 * n + 1);
    @(negedge Clk); #1;
    check("stall_fall", stall_fall_cyc, done_cyc + 1);
    check("busy_idle", {31'd0, Busy}, 32'd0);
    check("rdy_in_write", bad_rdy, 0);
    check("no_err_in_load", err_cnt - err_before, 0);
  endtask

  task automatic bad_cmd(input int len);
    int s;
    int bh;
    int wn;
    err_before = err_cnt;
    bh = busy_hi;
    wn = we_q.size();
    @(posedge Clk); #1;
    Start = 1'b1;
    Len   = LEN_W'(len);
    @(negedge Clk);
    s = cyc;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("err_pulses", err_cnt - err_before, 1);
    check("err_timing", err_cyc, s + 1);
    check("err_no_busy", busy_hi - bh, 0);
    check("err_no_we", we_q.size() - wn, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   {31'd0, Rx_Ready},  32'd0);
    check({tag, "_we"},    {31'd0, Mem_WE},    32'd0);
    check({tag, "_stall"}, {31'd0, Cpu_Stall}, 32'd0);
    check({tag, "_busy"},  {31'd0, Busy},      32'd0);
    check({tag, "_done"},  {31'd0, Done},      32'd0);
    check({tag, "_err"},   {31'd0, Err},       32'd0);
    check({tag, "_data"},  Mem_Data,           32'd0);
    check({tag, "_addr"},  Mem_Addr,           PC);
  endtask

  initial begin
    // Reset state.
    PC = 32'h0000_1234;
    #1;
    check_reset_outputs("reset");
    #12;
    Rst_n = 1'b1;

    // Address mux while idle follows PC combinationally.
    @(posedge Clk); #1;
    PC = 32'h0000_0010;
    #1;
    check("idle_pc_mux", Mem_Addr, 32'h0000_0010);
    PC = $urandom;
    #1;
    check("idle_pc_mux_rand", Mem_Addr, PC);

    // Directed 2-word load: bytes 13 00 00 00 93 00 60 00.
    words.delete();
    words.push_back(NOP_INSTR);
    words.push_back(32'h0060_0093);
    make_bytes();
    feed(2, 0, 8, 1'b0);
    finish_load(2, 0);

    // Illegal lengths.
    bad_cmd(0);
    bad_cmd(MEM_DEPTH + 1);

    // Valid toggled every other cycle on a 1-word load.
    gen(1);
    feed(1, 1, 4, 1'b0);
    finish_load(1, 1);

    // Start while busy must be ignored (Len=1 re-request mid-load).
    gen(2);
    feed(2, 0, 8, 1'b1);
    finish_load(2, 0);

    // Asynchronous reset after 6 bytes of a 3-word load.
    gen(3);
    feed(3, 0, 6, 1'b0);
    check("rst_pre_we_count", we_q.size(), 1);
    #2;
    Rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    gen(1);
    feed(1, 0, 4, 1'b0);
    finish_load(1, 0);

    // Randomized loads with random valid patterns.
    for (int r = 0; r < 5; r++) begin
      int n;
      int m;
      n = $urandom_range(1, 8);
      m = $urandom_range(0, 2);
      gen(n);
      feed(n, m, 4 * n, 1'b0);
      finish_load(n, m);
    end

    // Largest legal load fills every word address.
    gen(MEM_DEPTH);
    feed(MEM_DEPTH, 0, 4 * MEM_DEPTH, 1'b0);
    finish_load(MEM_DEPTH, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader and port arbiter for the instruction memory. It receives a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words. It writes those words to consecutive word addresses starting at 0, and holds the CPU stalled while loading. When idle, it forwards the CPU fetch address to the memory's shared address port unchanged.

## Interface
Parameters:
- MEM_DEPTH, 256, instruction memory depth in 32-bit words; maximum legal load length.
- LEN_W, 16, width of the Len input.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- Len  in  LEN_W  number of words to load; captured when Start is accepted.
- Rx_Data  in  8  stream byte, least-significant byte of each word first.
- Rx_Valid  in  1  Rx_Data is valid.
- Rx_Ready  out  1  loader accepts a byte this cycle.
- PC  in  32  CPU fetch address.
- Mem_Addr  out  32  memory address port.
- Mem_Data  out  32  memory write data.
- Mem_WE  out  1  memory write enable.
- Cpu_Stall  out  1  CPU must hold its PC and state.
- Busy  out  1  a load is in progress.
- Done  out  1  one-cycle pulse when a load completes.
- Err  out  1  one-cycle pulse when Start is rejected.

## Operation
- FSM states: IDLE, RECV, WRITE, FIN.
- IDLE:
  - Start with 1 ≤ Len ≤ MEM_DEPTH: capture Len, clear word_idx and byte_cnt, go to RECV.
  - Start with Len == 0 or Len > MEM_DEPTH: pulse Err next cycle, stay in IDLE.
- RECV:
  - Rx_Ready = 1. A byte is accepted when Rx_Valid && Rx_Ready.
  - The accepted byte goes into shift register lane byte_cnt, and byte_cnt increments (2-bit, wraps).
  - Accepting the byte with byte_cnt == 3 goes to WRITE.
- WRITE:
  - Mem_WE = 1, Mem_Addr = {word_idx, 2'b00} zero-extended, Mem_Data = assembled word. Rx_Ready = 0.
  - If word_idx == Len-1, go to FIN; otherwise increment word_idx and go to RECV.
- FIN: Done = 1 for one cycle, then go to IDLE.
- Address mux: Mem_Addr = PC in IDLE; otherwise the loader address.
- Mem_WE is asserted only in WRITE. Mem_Data = assembled word in every state (don't-care when WE = 0).
- Cpu_Stall = Busy = 1 in RECV, WRITE and FIN.
- Start outside IDLE is ignored, with no Err.
- Rx_Valid in IDLE, WRITE or FIN is not accepted; the byte waits upstream.
- word_idx is log2(MEM_DEPTH) bits wide; the Len check guarantees it never wraps.
- Reset mid-load:
  - Immediately go to IDLE; Mem_WE, Rx_Ready, Cpu_Stall, Busy, Done and Err all 0.
  - Words already written remain in memory; a partially assembled word is discarded.

## Timing
- Reset values:
  - State IDLE; word_idx, byte_cnt and data register 0.
  - Outputs: Rx_Ready 0, Mem_WE 0, Mem_Data 0, Cpu_Stall 0, Busy 0, Done 0, Err 0, Mem_Addr = PC.
- Busy and Cpu_Stall rise in the cycle after Start is accepted.
- Mem_WE asserts in the cycle after the 4th byte of a word is accepted.
- Minimum 5 cycles per word with Rx_Valid held high. An N-word load takes 5N+1 cycles from Start acceptance to the end of the Done pulse.
- Done is asserted in the cycle after the last WE; Cpu_Stall falls in the following cycle.
- All outputs are registered-state decodes, except Mem_Addr, which is combinational from PC in IDLE.

## Structure
- Shared package cpu_pkg:
  - loader_state_t enum: IDLE, RECV, WRITE, FIN.
  - NOP_INSTR constant 32'h00000013.
- Natural sub-module: byte_packer, a 4-byte shift register plus byte_cnt with a word_valid output.
- Top level holds the FSM, word counter, Len register and address mux.

## Test plan
- Reset, then Start with Len = 2 and bytes 13,00,00,00,93,00,60,00:
  - Required: WE at addresses 0x0 then 0x4, with data 0x00000013 then 0x00600093.
  - Required: Done one cycle after the second WE.
- Len = 0, and separately Len = MEM_DEPTH+1: Err pulses once, Busy stays 0, no WE.
- Rx_Valid toggled every other cycle during a 1-word load:
  - Required: the word still assembles correctly.
  - Required: Rx_Ready is never high in WRITE.
- PC = 0x0000_0010 while IDLE: Mem_Addr = 0x10. During a load, Mem_Addr follows the loader index regardless of PC.
- Rst_n pulsed low after 6 bytes of a 3-word load:
  - Required: exactly one WE has occurred.
  - Required: all outputs return to reset values asynchronously, and a new Start then loads from address 0.
- Start asserted while Busy: ignored, with no Err and no change to Len or word_idx.
